// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 4-stage IF/ID/EX-MEM/WB pipeline: PC load, buffer enables/flushes, stalls, redirects, halt.
// Optional performance counters (stall_count, flush_count) are built only when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       id_rs,
  input  logic [5:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [5:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             dm_ready,
  input  logic [1:0]       pc_change,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exwb_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RUN      = 3'd1;
  localparam logic [2:0] ST_REDIRECT = 3'd2;
  localparam logic [2:0] ST_MEM_WAIT = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;

  // One shared sequence counter: redirect, memory-wait and drain phases never overlap.
  localparam int M1   = (FLUSH_CYCLES > MEM_TIMEOUT) ? FLUSH_CYCLES : MEM_TIMEOUT;
  localparam int CMAX = (M1 > DRAIN_CYCLES) ? M1 : DRAIN_CYCLES;
  localparam int CW   = $clog2(CMAX + 2);

  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ZERO_C    = {CW{1'b0}};
  localparam logic [CW-1:0] TIMEOUT_C = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] FLUSH_C   = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_C   = CW'(DRAIN_CYCLES);

  logic [2:0]    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          err_r, err_nxt_s;
  logic          mem_busy_s, load_use_s, run_rules_s;

  assign mem_busy_s = (ex_mem_read | ex_mem_write) & ~dm_ready;
  assign load_use_s = ex_mem_read & (ex_rd != 6'd0) &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  assign state  = state_r;
  assign err    = err_r;
  assign halted = (state_r == ST_HALT);

  // Mealy output decode and next-state selection.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exwb_en     = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = err_r;
    run_rules_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (mem_busy_s) begin
          state_nxt_s = ST_MEM_WAIT;
          cnt_nxt_s   = ONE_C;
        end else begin
          run_rules_s = 1'b1;
        end
      end
      ST_REDIRECT: begin
        pc_en      = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        exwb_en    = 1'b1;
        if (cnt_r <= ONE_C) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = ZERO_C;
        end else begin
          cnt_nxt_s   = cnt_r - ONE_C;
        end
      end
      ST_MEM_WAIT: begin
        if (dm_ready) begin
          run_rules_s = 1'b1;
        end else if ((cnt_r + ONE_C) >= TIMEOUT_C) begin
          err_nxt_s   = 1'b1;
          state_nxt_s = ST_HALT;
          cnt_nxt_s   = ZERO_C;
        end else begin
          cnt_nxt_s   = cnt_r + ONE_C;
        end
      end
      ST_DRAIN: begin
        if (mem_busy_s) begin
          cnt_nxt_s = cnt_r;
        end else begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          exwb_en    = 1'b1;
          if (cnt_r <= ONE_C) begin
            state_nxt_s = ST_HALT;
            cnt_nxt_s   = ZERO_C;
          end else begin
            cnt_nxt_s   = cnt_r - ONE_C;
          end
        end
      end
      ST_HALT: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = ZERO_C;
      end
    endcase

    // Events modify the all-enabled RUN base in priority order: redirect, halt, load-use.
    if (run_rules_s) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exwb_en     = 1'b1;
      state_nxt_s = ST_RUN;
      cnt_nxt_s   = ZERO_C;
      if (pc_change != 2'b00) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_nxt_s = ST_REDIRECT;
          cnt_nxt_s   = FLUSH_C;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end else if (halt_req) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (DRAIN_CYCLES > 0) begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = DRAIN_C;
        end else begin
          state_nxt_s = ST_HALT;
        end
      end else if (load_use_s) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else begin
        state_nxt_s = ST_RUN;
      end
    end else begin
      err_nxt_s = err_nxt_s;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= ZERO_C;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             stall_s, redirect_s;

  assign stall_s    = ((state_r == ST_RUN) | (state_r == ST_MEM_WAIT)) & ~pc_en;
  assign redirect_s = run_rules_s & (pc_change != 2'b00);

  // Saturating stall and redirect-event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) stall_cnt_r <= stall_cnt_r + CNT_ONE;
      else                                           stall_cnt_r <= stall_cnt_r;
      if (redirect_s && (flush_cnt_r != {CNT_W{1'b1}})) flush_cnt_r <= flush_cnt_r + CNT_ONE;
      else                                              flush_cnt_r <= flush_cnt_r;
    end
  end

  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;
`else
  assign stall_count = {CNT_W{1'b0}};
  assign flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed per-cycle expectations, a monitor compares on the falling edge.
module tb_pipe_ctrl;
  logic        clk = 1'b1;
  logic        rst_n;
  logic        start, id_uses_rs, id_uses_rt, ex_mem_read, ex_mem_write, dm_ready, halt_req;
  logic [5:0]  id_rs, id_rt, ex_rd;
  logic [1:0]  pc_change;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en, halted, err;
  logic [2:0]  state;
  logic [15:0] stall_count, flush_count;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Enable vectors ordered {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en}.
  localparam logic [5:0] Z      = 6'b000000;
  localparam logic [5:0] RUN_EN = 6'b110101;
  localparam logic [5:0] RED_EN = 6'b111111;
  localparam logic [5:0] HLT_EN = 6'b011111;
  localparam logic [5:0] LU_EN  = 6'b000111;
  localparam logic [5:0] RDS_EN = 6'b101101;
  localparam logic [5:0] DR_EN  = 6'b001011;

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  en;
    logic        er;
    logic        hl;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_cyc = 0;

  pipe_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15), .DRAIN_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .dm_ready(dm_ready),
    .pc_change(pc_change), .halt_req(halt_req), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush), .exwb_en(exwb_en),
    .state(state), .halted(halted), .err(err), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic defaults();
    start = 1'b0; id_rs = 6'd0; id_rt = 6'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_rd = 6'd0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; dm_ready = 1'b1;
    pc_change = 2'b00; halt_req = 1'b0;
  endtask

  // Queue this cycle's expectation, then advance to just after the next rising edge.
  task automatic cyc(input logic [2:0] st, input logic [5:0] en, input logic er, input int sc, input int fc);
    obs_t e;
    e.st = st; e.en = en; e.er = er; e.hl = (st == 3'd5);
    e.sc = PERF ? 16'(sc) : 16'd0;
    e.fc = PERF ? 16'(fc) : 16'd0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    defaults();
  endtask

  // Monitor: one observation per cycle, compared against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        obs_t e, a;
        e = exp_q.pop_front();
        a = {state, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exwb_en, err, halted, stall_count, flush_count};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cyc%0d: got st=%0d en=%b err=%b halted=%b sc=%0d fc=%0d, want st=%0d en=%b err=%b halted=%b sc=%0d fc=%0d",
                   mon_cyc, a.st, a.en, a.er, a.hl, a.sc, a.fc, e.st, e.en, e.er, e.hl, e.sc, e.fc);
        end
        mon_cyc++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    defaults();
    cyc(3'd0, Z, 1'b0, 0, 0);                                        // c0 in reset
    rst_n = 1'b1;
    cyc(3'd0, Z, 1'b0, 0, 0);                                        // c1 idle
    start = 1'b1;               cyc(3'd0, Z, 1'b0, 0, 0);            // c2 start pulse
    cyc(3'd1, RUN_EN, 1'b0, 0, 0);                                   // c3 run
    // load-use on rs, then clear
    ex_mem_read = 1'b1; ex_rd = 6'd5; id_rs = 6'd5; id_uses_rs = 1'b1;
    cyc(3'd1, LU_EN, 1'b0, 0, 0);
    cyc(3'd1, RUN_EN, 1'b0, 1, 0);
    // ex_rd = 0 never stalls
    ex_mem_read = 1'b1; ex_rd = 6'd0; id_rs = 6'd0; id_uses_rs = 1'b1;
    cyc(3'd1, RUN_EN, 1'b0, 1, 0);
    // load-use on rt
    ex_mem_read = 1'b1; ex_rd = 6'd7; id_rs = 6'd7; id_rt = 6'd7; id_uses_rt = 1'b1;
    cyc(3'd1, LU_EN, 1'b0, 1, 0);
    cyc(3'd1, RUN_EN, 1'b0, 2, 0);
    // match only on an unused field
    ex_mem_read = 1'b1; ex_rd = 6'd3; id_rs = 6'd4; id_uses_rs = 1'b1; id_rt = 6'd3;
    cyc(3'd1, RUN_EN, 1'b0, 2, 0);
    // redirect with two flush cycles
    pc_change = 2'b01;          cyc(3'd1, RED_EN, 1'b0, 2, 0);
    cyc(3'd2, RDS_EN, 1'b0, 2, 1);
    cyc(3'd1, RUN_EN, 1'b0, 2, 1);
    // pc_change=11 redirects; pc_change in REDIRECT is ignored
    pc_change = 2'b11;          cyc(3'd1, RED_EN, 1'b0, 2, 1);
    pc_change = 2'b01;          cyc(3'd2, RDS_EN, 1'b0, 2, 2);
    cyc(3'd1, RUN_EN, 1'b0, 2, 2);
    // three frozen cycles, then jump_mem redirect on completion
    ex_mem_read = 1'b1; dm_ready = 1'b0; cyc(3'd1, Z, 1'b0, 2, 2);
    ex_mem_read = 1'b1; dm_ready = 1'b0; cyc(3'd3, Z, 1'b0, 3, 2);
    ex_mem_read = 1'b1; dm_ready = 1'b0; cyc(3'd3, Z, 1'b0, 4, 2);
    ex_mem_read = 1'b1; pc_change = 2'b10; cyc(3'd3, RED_EN, 1'b0, 5, 2);
    cyc(3'd2, RDS_EN, 1'b0, 5, 3);
    cyc(3'd1, RUN_EN, 1'b0, 5, 3);
    // store wait of one cycle with a plain completion
    ex_mem_write = 1'b1; dm_ready = 1'b0; cyc(3'd1, Z, 1'b0, 5, 3);
    ex_mem_write = 1'b1;                  cyc(3'd3, RUN_EN, 1'b0, 6, 3);
    cyc(3'd1, RUN_EN, 1'b0, 6, 3);
    // memory timeout: 15 consecutive not-ready cycles
    ex_mem_read = 1'b1; dm_ready = 1'b0; cyc(3'd1, Z, 1'b0, 6, 3);
    for (int i = 0; i < 14; i++) begin
      ex_mem_read = 1'b1; dm_ready = 1'b0;
      cyc(3'd3, Z, 1'b0, 7 + i, 3);
    end
    cyc(3'd5, Z, 1'b1, 21, 3);
    start = 1'b1;               cyc(3'd5, Z, 1'b1, 21, 3);
    cyc(3'd1, RUN_EN, 1'b0, 21, 3);
    // halt with two drain cycles
    halt_req = 1'b1;            cyc(3'd1, HLT_EN, 1'b0, 21, 3);
    cyc(3'd4, DR_EN, 1'b0, 22, 3);
    cyc(3'd4, DR_EN, 1'b0, 22, 3);
    cyc(3'd5, Z, 1'b0, 22, 3);
    // a memory wait freezes DRAIN without counting stalls
    start = 1'b1;               cyc(3'd5, Z, 1'b0, 22, 3);
    cyc(3'd1, RUN_EN, 1'b0, 22, 3);
    halt_req = 1'b1;            cyc(3'd1, HLT_EN, 1'b0, 22, 3);
    ex_mem_read = 1'b1; dm_ready = 1'b0; cyc(3'd4, Z, 1'b0, 23, 3);
    cyc(3'd4, DR_EN, 1'b0, 23, 3);
    cyc(3'd4, DR_EN, 1'b0, 23, 3);
    cyc(3'd5, Z, 1'b0, 23, 3);
    // asynchronous reset in the middle of a redirect
    start = 1'b1;               cyc(3'd5, Z, 1'b0, 23, 3);
    pc_change = 2'b01;          cyc(3'd1, RED_EN, 1'b0, 23, 3);
    rst_n = 1'b0;               cyc(3'd0, Z, 1'b0, 0, 0);
    rst_n = 1'b1;               cyc(3'd0, Z, 1'b0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
